// File: rtl/p2p_xform_pkg.sv
// Shared types and the word transform used by the p2p_xform_pipe stage-1 entry.
// Transform results are masked to the caller's width so one function serves every WIDTH.
package p2p_xform_pkg;

  localparam int COUNT_W = 32;

  typedef enum logic [1:0] {
    XF_INV  = 2'd0,
    XF_PASS = 2'd1,
    XF_INC  = 2'd2,
    XF_ROL  = 2'd3
  } xf_mode_e;

  function automatic logic [63:0] xform(input logic [63:0] data, input xf_mode_e mode,
                                        input int width);
    logic [63:0] mask;
    logic [63:0] res;
    mask = ~64'd0 >> (64 - width);
    case (mode)
      XF_INV:  res = ~data;
      XF_PASS: res = data;
      XF_INC:  res = data + 64'd1;
      XF_ROL:  res = (data << 1) | (data >> (width - 1));
      default: res = data;
    endcase
    return res & mask;
  endfunction

endpackage

// File: rtl/p2p_xform_stage.sv
// One pipeline slot of p2p_xform_pipe: a {valid, data} register that holds while stalled.
// Data is cleared on reset so the output word reads zero after reset.
module p2p_xform_stage #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_adv,
  input  logic             i_vld,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_vld,
  output logic [WIDTH-1:0] o_data
);

  logic             r_vld;
  logic [WIDTH-1:0] r_data;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_vld  <= 1'b0;
      r_data <= '0;
    end else if (i_adv) begin
      r_vld  <= i_vld;
      r_data <= i_data;
    end
  end

  assign o_vld  = r_vld;
  assign o_data = r_data;

endmodule

// File: rtl/p2p_xform_pipe.sv
// Stall-all DEPTH-stage transform pipeline between a point_slave_io slot and the host.
// Optional completed-transfer counter on xfer_count when P2P_XFORM_COUNT_EN is defined.
module p2p_xform_pipe
  import p2p_xform_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [WIDTH-1:0]   data_o,
  input  logic               valid_o,
  output logic               ready_o,
  input  logic [1:0]         mode,
  output logic [WIDTH-1:0]   data_i,
  output logic               valid_i,
  input  logic               ready_i
`ifdef P2P_XFORM_COUNT_EN
  ,output logic [COUNT_W-1:0] xfer_count
`endif
);

  logic             w_stall;
  logic             w_adv;
  logic [63:0]      w_din_ext_p0;
  logic [63:0]      w_xf_ext_p0;
  logic             w_vld_p  [0:DEPTH];
  logic [WIDTH-1:0] w_data_p [0:DEPTH];

  // A held output blocks the whole pipe, including the input side.
  assign w_stall = valid_i && !ready_i;
  assign w_adv   = !w_stall;
  assign ready_o = !reset && !w_stall;

  // Stage-1 entry: transform applied as the word is captured, so each word keeps its own mode.
  assign w_din_ext_p0 = 64'(data_o);
  assign w_xf_ext_p0  = xform(w_din_ext_p0, xf_mode_e'(mode), WIDTH);
  assign w_vld_p[0]   = valid_o;
  assign w_data_p[0]  = WIDTH'(w_xf_ext_p0);

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    p2p_xform_stage #(.WIDTH(WIDTH)) u_stage (
      .clock  (clock),
      .reset  (reset),
      .i_adv  (w_adv),
      .i_vld  (w_vld_p[k]),
      .i_data (w_data_p[k]),
      .o_vld  (w_vld_p[k+1]),
      .o_data (w_data_p[k+1])
    );
  end

  assign valid_i = w_vld_p[DEPTH];
  assign data_i  = w_data_p[DEPTH];

`ifdef P2P_XFORM_COUNT_EN
  logic [COUNT_W-1:0] r_xfer_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_xfer_count <= '0;
    end else if (valid_i && ready_i) begin
      r_xfer_count <= r_xfer_count + 1'b1;
    end
  end

  assign xfer_count = r_xfer_count;
`endif

endmodule

// File: tb/tb_p2p_xform_pipe.sv
// Self-checking bench for p2p_xform_pipe: directed scenarios plus a queue-based
// scoreboard that tracks every accepted word until it leaves the pipe.
module tb_p2p_xform_pipe;

  localparam int WIDTH = 16;
  localparam int DEPTH = 3;

  logic             clock   = 1'b0;
  logic             reset   = 1'b1;
  logic [WIDTH-1:0] data_o  = '0;
  logic             valid_o = 1'b0;
  logic             ready_o;
  logic [1:0]       mode    = 2'd0;
  logic [WIDTH-1:0] data_i;
  logic             valid_i;
  logic             ready_i = 1'b1;
`ifdef P2P_XFORM_COUNT_EN
  logic [31:0]      xfer_count;
`endif

  always #5 clock = ~clock;

  p2p_xform_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_dut (
    .clock   (clock),
    .reset   (reset),
    .data_o  (data_o),
    .valid_o (valid_o),
    .ready_o (ready_o),
    .mode    (mode),
    .data_i  (data_i),
    .valid_i (valid_i),
    .ready_i (ready_i)
`ifdef P2P_XFORM_COUNT_EN
    ,.xfer_count (xfer_count)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;
  int adv      = 0;
  int n_xfers  = 0;

  typedef struct {
    logic [WIDTH-1:0] d;
    int               a;
  } exp_t;
  exp_t q[$];

  // Reference transform written as plain modular arithmetic.
  function automatic logic [WIDTH-1:0] ref_xf(input logic [WIDTH-1:0] d, input logic [1:0] m);
    longint unsigned full;
    longint unsigned v;
    longint unsigned r;
    full = 64'd1 << WIDTH;
    v    = 64'(d);
    case (m)
      2'd0:    r = full - 1 - v;
      2'd1:    r = v;
      2'd2:    r = (v + 1) % full;
      default: r = (v * 2) % full + v / (full / 2);
    endcase
    return r[WIDTH-1:0];
  endfunction

  // Scoreboard: a word accepted at advance number A is on the output once DEPTH-1 further advances happen.
  always @(negedge clock) begin : mon
    logic ev;
    logic er;
    exp_t e;
    if (mon_en) begin
      ev = (q.size() > 0) && ((adv - q[0].a) == DEPTH - 1);
      n_checks++;
      if (valid_i !== ev) begin
        n_fail++;
        $display("FAIL sb_valid_i at %0t: got %b required %b", $time, valid_i, ev);
      end
      if (ev) begin
        n_checks++;
        if (data_i !== q[0].d) begin
          n_fail++;
          $display("FAIL sb_data_i at %0t: got %h required %h", $time, data_i, q[0].d);
        end
      end
      er = !reset && !(ev && !ready_i);
      n_checks++;
      if (ready_o !== er) begin
        n_fail++;
        $display("FAIL sb_ready_o at %0t: got %b required %b", $time, ready_o, er);
      end
      if (reset) begin
        q.delete();
      end else if (!(ev && !ready_i)) begin
        adv++;
        if (ev) begin
          void'(q.pop_front());
          n_xfers++;
        end
        if (valid_o) begin
          e.d = ref_xf(data_o, mode);
          e.a = adv;
          q.push_back(e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; valid_o = 1'b0; ready_i = 1'b1;
    repeat (2) tick();
    mon_en = 1'b1;
    @(negedge clock);
    n_checks++;
    if (ready_o !== 1'b0) begin n_fail++; $display("FAIL rst_ready_o: got %b required 0", ready_o); end
    n_checks++;
    if (valid_i !== 1'b0) begin n_fail++; $display("FAIL rst_valid_i: got %b required 0", valid_i); end
    n_checks++;
    if (data_i !== '0) begin n_fail++; $display("FAIL rst_data_i: got %h required 0", data_i); end
    tick();
    reset = 1'b0;
    @(negedge clock);
    n_checks++;
    if (ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready_o: got %b required 1", ready_o); end
  endtask

  task automatic test_legacy();
    for (int c = 1; c <= DEPTH + 2; c++) begin
      tick();
      valid_o = (c == 1); data_o = 16'h00FF; mode = 2'd0; ready_i = 1'b1;
      @(negedge clock);
      if (c == 1) begin
        n_checks++;
        if (ready_o !== 1'b1) begin n_fail++; $display("FAIL legacy_accept: got %b required 1", ready_o); end
      end
      if (c == DEPTH + 1) begin
        n_checks++;
        if (valid_i !== 1'b1 || data_i !== 16'hFF00) begin
          n_fail++; $display("FAIL legacy_out: got v=%b d=%h required v=1 d=ff00", valid_i, data_i);
        end
      end
      if (c == DEPTH + 2) begin
        n_checks++;
        if (valid_i !== 1'b0) begin n_fail++; $display("FAIL legacy_after: got %b required 0", valid_i); end
      end
    end
  endtask

  task automatic test_modes();
    logic [WIDTH-1:0] din  [3];
    logic [1:0]       dm   [3];
    logic [WIDTH-1:0] dexp [3];
    din  = '{16'h1234, 16'hFFFF, 16'h8001};
    dm   = '{2'd1, 2'd2, 2'd3};
    dexp = '{16'h1234, 16'h0000, 16'h0003};
    for (int c = 1; c <= DEPTH + 4; c++) begin
      tick();
      valid_o = (c <= 3); ready_i = 1'b1;
      if (c <= 3) begin data_o = din[c-1]; mode = dm[c-1]; end
      @(negedge clock);
      if (c >= DEPTH + 1 && c <= DEPTH + 3) begin
        n_checks++;
        if (valid_i !== 1'b1 || data_i !== dexp[c-DEPTH-1]) begin
          n_fail++;
          $display("FAIL modes_word%0d: got v=%b d=%h required v=1 d=%h",
                   c - DEPTH - 1, valid_i, data_i, dexp[c-DEPTH-1]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int wi;
    int x0;
    wi = 0; x0 = n_xfers;
    for (int c = 1; c <= DEPTH + 12; c++) begin
      tick();
      valid_o = (c <= DEPTH + 8);
      data_o  = WIDTH'(16'hA000 + wi);
      mode    = 2'(wi);
      ready_i = (c > DEPTH + 4);
      @(negedge clock);
      if (c > DEPTH && c <= DEPTH + 4) begin
        n_checks++;
        if (ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_stall_ready_o c=%0d: got %b required 0", c, ready_o); end
      end
      if (valid_o && ready_o) wi++;
    end
    n_checks++;
    if (q.size() != 0 || (n_xfers - x0) != wi) begin
      n_fail++; $display("FAIL bp_count: got out=%0d left=%0d required out=%0d left=0", n_xfers - x0, q.size(), wi);
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 1; c <= DEPTH + 5; c++) begin
      tick();
      valid_o = (c <= 2); data_o = WIDTH'(16'h5A00 + c); mode = 2'd1; ready_i = 1'b1;
      reset   = (c == 3);
      @(negedge clock);
      if (c == 3) begin
        n_checks++;
        if (ready_o !== 1'b0) begin n_fail++; $display("FAIL rmid_ready_in_reset: got %b required 0", ready_o); end
      end
      if (c == 4) begin
        n_checks++;
        if (ready_o !== 1'b1 || data_i !== '0) begin
          n_fail++; $display("FAIL rmid_after: got rdy=%b d=%h required rdy=1 d=0", ready_o, data_i);
        end
      end
      if (c >= 3) begin
        n_checks++;
        if (valid_i !== 1'b0) begin n_fail++; $display("FAIL rmid_dropped c=%0d: got %b required 0", c, valid_i); end
      end
    end
  endtask

  task automatic test_bubbles();
    logic pat [3];
    pat = '{1'b1, 1'b0, 1'b1};
    for (int c = 1; c <= DEPTH + 4; c++) begin
      tick();
      valid_o = (c <= 3) ? pat[c-1] : 1'b0;
      data_o  = WIDTH'(16'h0100 * c); mode = 2'd1; ready_i = 1'b1;
      @(negedge clock);
      if (c == DEPTH || c == DEPTH + 4) begin
        n_checks++;
        if (valid_i !== 1'b0) begin n_fail++; $display("FAIL bubble_edge c=%0d: got %b required 0", c, valid_i); end
      end
      if (c >= DEPTH + 1 && c <= DEPTH + 3) begin
        n_checks++;
        if (valid_i !== pat[c-DEPTH-1]) begin
          n_fail++; $display("FAIL bubble_pat c=%0d: got %b required %b", c, valid_i, pat[c-DEPTH-1]);
        end
      end
    end
  endtask

  task automatic drain(input string tag);
    int guard;
    guard = 0;
    while (q.size() != 0 && guard < 50) begin
      tick();
      valid_o = 1'b0; ready_i = 1'b1;
      @(negedge clock);
      guard++;
    end
    n_checks++;
    if (q.size() != 0) begin n_fail++; $display("FAIL %s_drain: got %0d words left required 0", tag, q.size()); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      tick();
      valid_o = ($urandom % 4) != 0;
      ready_i = ($urandom % 3) != 0;
      data_o  = WIDTH'($urandom);
      mode    = 2'($urandom);
      @(negedge clock);
    end
    drain("random");
  endtask

`ifdef P2P_XFORM_COUNT_EN
  task automatic test_counter();
    int wi;
    int guard;
    tick(); reset = 1'b1; valid_o = 1'b0;
    tick(); reset = 1'b0;
    wi = 0; guard = 0;
    while (wi < 10 && guard < 200) begin
      valid_o = 1'b1; data_o = WIDTH'($urandom); mode = 2'($urandom);
      ready_i = ($urandom % 2) != 0;
      @(negedge clock);
      if (ready_o) wi++;
      tick();
      guard++;
    end
    valid_o = 1'b0;
    @(negedge clock);
    drain("counter");
    n_checks++;
    if (xfer_count !== 32'd10) begin n_fail++; $display("FAIL count_10: got %0d required 10", xfer_count); end
    u_dut.r_xfer_count = 32'hFFFF_FFFF;
    tick();
    valid_o = 1'b1; data_o = 16'h0001; mode = 2'd1; ready_i = 1'b1;
    @(negedge clock);
    tick();
    valid_o = 1'b0;
    @(negedge clock);
    drain("wrap");
    n_checks++;
    if (xfer_count !== 32'd0) begin n_fail++; $display("FAIL count_wrap: got %h required 0", xfer_count); end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_legacy();
    test_modes();
    test_backpressure();
    drain("bp");
    test_reset_mid();
    test_bubbles();
    test_random();
`ifdef P2P_XFORM_COUNT_EN
    test_counter();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
